sad_disparity_scheduler: RTL and testbench

Sequencing controller for the combinational SAD (sum of absolute differences) mask datapath in the stereo-matching path. Per search it loads one left MASK_SIZE×MASK_SIZE mask from a pixel stream. It then loads one right mask per candidate disparity, presents each left/right pair to the SAD datapath and records the lowest-cost disparity. It sits between the AXI-side pixel buffer and the result register bank.

---
 rtl/sad_disparity_scheduler.sv | 163 ++++++++++++++++
 tb/tb_sad_disparity_scheduler.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sad_disparity_scheduler.sv
// sad_disparity_scheduler
// Purpose : sequences one stereo disparity search. It loads a left mask, then one
//           right mask per candidate disparity. Each left/right pair goes to the
//           combinational SAD datapath, and the lowest-cost disparity is tracked.
// Latency : with in_valid held high, result_valid rises 1+N+MAX_DISPARITY*(N+1)
//           cycles after start is sampled (N = MASK_SIZE*MASK_SIZE).
// Backpressure: gaps in in_valid only stall the beat counter. in_ready is high
//           only while a mask is loading. The result is held until result_ready.
//
// Ports:
//   S_AXI_ACLK / S_AXI_ARESET   clock and synchronous active-high reset
//   start, busy                 search launch (sampled in IDLE) and activity flag
//   in_data/in_valid/in_ready   pixel beat stream, cell 0 first
//   sad_left, sad_right         registered masks driving the SAD datapath
//   sad_in, sad_strobe          SAD returned by the datapath, EVAL-cycle marker
//   best_disp, best_sad         winning disparity and its SAD
//   result_valid/result_ready   result handshake

module sad_disparity_scheduler #(
  parameter int MASK_SIZE     = 3,
  parameter int PIXEL_WIDTH   = 8,
  parameter int SUM_WIDTH     = 12,
  parameter int MAX_DISPARITY = 16,
  parameter int DISP_WIDTH    = 4
) (
  input  logic                                     S_AXI_ACLK,
  input  logic                                     S_AXI_ARESET,
  input  logic                                     start,
  output logic                                     busy,
  input  logic [PIXEL_WIDTH-1:0]                   in_data,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  output logic [MASK_SIZE*MASK_SIZE*PIXEL_WIDTH-1:0] sad_left,
  output logic [MASK_SIZE*MASK_SIZE*PIXEL_WIDTH-1:0] sad_right,
  input  logic [SUM_WIDTH-1:0]                     sad_in,
  output logic                                     sad_strobe,
  output logic [DISP_WIDTH-1:0]                    best_disp,
  output logic [SUM_WIDTH-1:0]                     best_sad,
  output logic                                     result_valid,
  input  logic                                     result_ready
);

  localparam int N     = MASK_SIZE * MASK_SIZE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [CNT_W-1:0]      LAST_CELL = CNT_W'(N - 1);
  localparam logic [DISP_WIDTH-1:0] LAST_DISP = DISP_WIDTH'(MAX_DISPARITY - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_L = 3'd1,
    LOAD_R = 3'd2,
    EVAL   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;   // cell index of the next accepted beat
  logic [DISP_WIDTH-1:0] disp;  // disparity currently being loaded / evaluated
  logic                  beat;

  // in_ready is a registered copy of "state is LOAD_L or LOAD_R", so a beat
  // can only be taken while a mask is loading.
  assign beat = in_valid & in_ready;

  // The state and every output register live in one block. Each output is set
  // on the transition into the state that owns it, so all outputs come
  // straight from flops and match the state they describe.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state        <= IDLE;
      cnt          <= '0;
      disp         <= '0;
      busy         <= 1'b0;
      in_ready     <= 1'b0;
      sad_strobe   <= 1'b0;
      result_valid <= 1'b0;
      sad_left     <= '0;
      sad_right    <= '0;
      best_disp    <= '0;
      best_sad     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD_L;
            busy     <= 1'b1;
            in_ready <= 1'b1;
            cnt      <= '0;
            disp     <= '0;
          end
        end

        LOAD_L: begin
          if (beat) begin
            sad_left[int'(cnt)*PIXEL_WIDTH +: PIXEL_WIDTH] <= in_data;
            if (cnt == LAST_CELL) begin
              cnt   <= '0;
              state <= LOAD_R;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        LOAD_R: begin
          // The right mask is overwritten cell by cell. Cells not yet reloaded
          // still hold the previous disparity's pixels. This is harmless
          // because the SAD is only sampled in EVAL, after all N cells are in.
          if (beat) begin
            sad_right[int'(cnt)*PIXEL_WIDTH +: PIXEL_WIDTH] <= in_data;
            if (cnt == LAST_CELL) begin
              cnt        <= '0;
              state      <= EVAL;
              in_ready   <= 1'b0;
              sad_strobe <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        EVAL: begin
          // Both masks have been stable since the last beat, so sad_in settles
          // within this cycle. The strict '<' keeps the lower disparity on
          // ties. The first disparity always seeds the running best.
          if ((disp == '0) || (sad_in < best_sad)) begin
            best_sad  <= sad_in;
            best_disp <= disp;
          end
          sad_strobe <= 1'b0;
          if (disp == LAST_DISP) begin
            state        <= DONE;
            result_valid <= 1'b1;
          end else begin
            disp     <= disp + 1'b1;
            state    <= LOAD_R;
            in_ready <= 1'b1;
          end
        end

        DONE: begin
          // result_valid was raised on entry, so it is high for at least one
          // full cycle before a handshake can complete.
          if (result_ready) begin
            state        <= IDLE;
            result_valid <= 1'b0;
            busy         <= 1'b0;
          end
        end

        default: begin
          state        <= IDLE;
          busy         <= 1'b0;
          in_ready     <= 1'b0;
          sad_strobe   <= 1'b0;
          result_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sad_disparity_scheduler.sv
module tb_sad_disparity_scheduler;

  localparam int MS = 3;
  localparam int PW = 8;
  localparam int SW = 12;
  localparam int MD = 16;
  localparam int DW = 4;
  localparam int N  = MS * MS;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              busy;
  logic [PW-1:0]     in_data;
  logic              in_valid;
  logic              in_ready;
  logic [N*PW-1:0]   sad_left;
  logic [N*PW-1:0]   sad_right;
  logic [SW-1:0]     sad_in;
  logic              sad_strobe;
  logic [DW-1:0]     best_disp;
  logic [SW-1:0]     best_sad;
  logic              result_valid;
  logic              result_ready;

  always #5 clk = ~clk;

  sad_disparity_scheduler #(
    .MASK_SIZE(MS), .PIXEL_WIDTH(PW), .SUM_WIDTH(SW),
    .MAX_DISPARITY(MD), .DISP_WIDTH(DW)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst), .start(start), .busy(busy),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sad_left(sad_left), .sad_right(sad_right), .sad_in(sad_in),
    .sad_strobe(sad_strobe), .best_disp(best_disp), .best_sad(best_sad),
    .result_valid(result_valid), .result_ready(result_ready)
  );

  // Combinational SAD datapath that the scheduler drives.
  int sad_acc;
  always_comb begin
    sad_acc = 0;
    for (int i = 0; i < N; i++) begin
      if (sad_left[i*PW +: PW] > sad_right[i*PW +: PW])
        sad_acc = sad_acc + int'(sad_left[i*PW +: PW]) - int'(sad_right[i*PW +: PW]);
      else
        sad_acc = sad_acc + int'(sad_right[i*PW +: PW]) - int'(sad_left[i*PW +: PW]);
    end
    sad_in = SW'(sad_acc);
  end

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int left_px[N];
  int right_px[MD][N];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_zero(input string name);
    check(name, {sad_left, sad_right, best_disp, best_sad, busy, in_ready,
                 sad_strobe, result_valid}, '0);
  endtask

  // Reference: SAD of each candidate disparity, earliest minimum wins.
  task automatic model(output int bd, output int bs);
    int sads[MD];
    int mn;
    for (int d = 0; d < MD; d++) begin
      sads[d] = 0;
      for (int i = 0; i < N; i++) begin
        sads[d] += (left_px[i] > right_px[d][i]) ? left_px[i] - right_px[d][i]
                                                 : right_px[d][i] - left_px[i];
      end
    end
    mn = sads[0];
    foreach (sads[d]) if (sads[d] < mn) mn = sads[d];
    bs = mn;
    bd = 0;
    for (int d = MD - 1; d >= 0; d--) if (sads[d] == mn) bd = d;
  endtask

  // kind 0: unique minimum at d=5, kind 1: tie, kind 2: random, kind 3: low-range random (ties)
  task automatic fill(input int kind);
    for (int i = 0; i < N; i++) begin
      case (kind)
        0:       left_px[i] = 1;
        1:       left_px[i] = 10;
        2:       left_px[i] = int'($urandom_range(0, 255));
        default: left_px[i] = int'($urandom_range(0, 3));
      endcase
      for (int d = 0; d < MD; d++) begin
        case (kind)
          0:       right_px[d][i] = 1 + ((d > 5) ? d - 5 : 5 - d);
          1:       right_px[d][i] = 11;
          2:       right_px[d][i] = int'($urandom_range(0, 255));
          default: right_px[d][i] = int'($urandom_range(0, 3));
        endcase
      end
    end
  endtask

  // gap: 0 continuous, 1 every other cycle, 2 random.
  // exp_disp < 0 means take expectations from the model.
  task automatic run_search(input string tag, input int gap, input int hold,
                            input bit noise, input int abort_d,
                            input int exp_disp, input int exp_sad, input int exp_cycle);
    int beats[$];
    int idx, rv_cycle, strobes, strobe_bad, busy_bad, hold_bad, ebd, ebs;
    bit fire, prev_strobe;
    logic [N*PW-1:0] lp;
    logic [DW-1:0] hd;
    logic [SW-1:0] hs;

    beats = {};
    for (int i = 0; i < N; i++) beats.push_back(left_px[i]);
    for (int d = 0; d < MD; d++)
      for (int i = 0; i < N; i++) beats.push_back(right_px[d][i]);
    model(ebd, ebs);
    if (exp_disp >= 0) begin
      ebd = exp_disp;
      ebs = exp_sad;
    end
    for (int i = 0; i < N; i++) lp[i*PW +: PW] = PW'(left_px[i]);

    @(negedge clk);  // cycle 0
    start = 1'b1;
    result_ready = 1'b0;
    in_valid = 1'b0;
    idx = 0; fire = 0; strobes = 0; strobe_bad = 0; busy_bad = 0;
    prev_strobe = 0; rv_cycle = -1;

    for (int c = 1; c < 3000; c++) begin
      @(negedge clk);
      if (fire) idx++;
      if (sad_strobe) begin
        strobes++;
        if (in_ready || prev_strobe) strobe_bad++;
      end
      prev_strobe = sad_strobe;
      if (!busy) busy_bad++;
      if (abort_d >= 0 && idx == N * (abort_d + 1) + 4 && in_ready) begin
        rst = 1'b1;
        start = 1'($urandom);
        in_valid = 1'($urandom);
        in_data = PW'($urandom);
        @(negedge clk);
        check_zero({tag, " mid-search reset zero"});
        rst = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        return;
      end
      if (result_valid) begin
        rv_cycle = c;
        break;
      end
      start = noise ? 1'($urandom) : 1'b0;
      case (gap)
        0:       in_valid = (idx < beats.size());
        1:       in_valid = (idx < beats.size()) && (c % 2 == 1);
        default: in_valid = (idx < beats.size()) && ($urandom_range(0, 9) < 7);
      endcase
      in_data = in_valid ? PW'(beats[idx]) : PW'($urandom);
      fire = in_valid && in_ready;
    end
    start = 1'b0;
    in_valid = 1'b0;

    if (rv_cycle < 0) begin
      check({tag, " result_valid timeout"}, 0, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      return;
    end
    if (exp_cycle > 0) check({tag, " result cycle"}, rv_cycle, exp_cycle);
    check({tag, " best_disp"}, best_disp, ebd);
    check({tag, " best_sad"}, best_sad, ebs);
    check({tag, " strobe count"}, strobes, MD);
    check({tag, " strobe shape/in_ready in EVAL"}, strobe_bad, 0);
    check({tag, " beats consumed"}, idx, beats.size());
    check({tag, " busy while searching"}, busy_bad, 0);
    check({tag, " left mask held"}, sad_left, lp);

    hd = best_disp;
    hs = best_sad;
    hold_bad = 0;
    for (int h = 0; h < hold; h++) begin
      start = noise ? 1'($urandom) : 1'b0;
      @(negedge clk);
      if (best_disp !== hd || best_sad !== hs || !result_valid || !busy || in_ready)
        hold_bad++;
    end
    start = 1'b0;
    if (hold > 0) check({tag, " result hold"}, hold_bad, 0);
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    check({tag, " idle after handshake"}, {result_valid, busy, in_ready}, 3'b000);
  endtask

  typedef struct {
    string name;
    int    kind;
    int    gap;
    int    hold;
    bit    noise;
    int    exp_disp;
    int    exp_sad;
    int    exp_cycle;
  } vec_t;

  vec_t tbl[4];

  initial begin
    tbl[0] = '{"unique",   0, 0, 0,  1'b0, 5, 0, 170};
    tbl[1] = '{"tie",      1, 0, 0,  1'b0, 0, 9, 170};
    tbl[2] = '{"backpres", 0, 1, 0,  1'b0, 5, 0, -1};
    tbl[3] = '{"hold",     0, 0, 10, 1'b1, 5, 0, 170};

    // Reset with random inputs for two cycles.
    rst = 1'b1;
    start = 1'b0; in_valid = 1'b0; in_data = '0; result_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      start = 1'($urandom);
      in_valid = 1'($urandom);
      in_data = PW'($urandom);
      result_ready = 1'($urandom);
    end
    @(negedge clk);
    check_zero("reset outputs");
    rst = 1'b0;
    start = 1'b0; in_valid = 1'b1; in_data = 8'h55; result_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("no start stays idle");
    in_valid = 1'b0;

    foreach (tbl[k]) begin
      fill(tbl[k].kind);
      run_search(tbl[k].name, tbl[k].gap, tbl[k].hold, tbl[k].noise, -1,
                 tbl[k].exp_disp, tbl[k].exp_sad, tbl[k].exp_cycle);
    end

    // Reset during LOAD_R of d=7, then a fresh search with the same data.
    fill(0);
    run_search("abort", 0, 0, 1'b0, 7, 5, 0, 170);
    run_search("after abort", 0, 0, 1'b0, -1, 5, 0, 170);

    // Randomized data and gaps against the reference model.
    for (int r = 0; r < 6; r++) begin
      fill((r % 2 == 0) ? 2 : 3);
      run_search($sformatf("rand%0d", r), 2, int'($urandom_range(0, 3)),
                 1'($urandom), -1, -1, 0, -1);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
